// File: rtl/mac_scheduler.sv
// rtl/mac_scheduler.sv - arbitrates N_REQ requesters onto one fixed-latency MAC datapath
// Define MAC_SCHED_FIXED_PRIO_EN for lowest-index-first arbitration instead of round-robin.
module mac_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int LAT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       op_a,
  output logic [W-1:0]       op_b,
  output logic               op_valid,
  input  logic [W-1:0]       res_d,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       d_out,
  output logic               busy
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    win, win_n, pick;
  logic             found;
  logic [3:0]       cnt, cnt_n;
  logic [N_REQ-1:0] gnt_n, done_n;
  logic [W-1:0]     op_a_n, op_b_n, d_out_n;
  logic             op_valid_n;
  logic [W-1:0]     a_arr [N_REQ];
  logic [W-1:0]     b_arr [N_REQ];
`ifndef MAC_SCHED_FIXED_PRIO_EN
  logic [IW-1:0]    last, last_n;
  logic [IW:0]      cand;
`endif

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = a_in[i*W +: W];
      b_arr[i] = b_in[i*W +: W];
    end
  end

  // Winner selection; only consumed while IDLE.
  always_comb begin
    pick  = '0;
    found = 1'b0;
`ifdef MAC_SCHED_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
`else
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ))
        cand = cand - (IW+1)'(N_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        pick  = cand[IW-1:0];
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_n    = state;
    win_n      = win;
    cnt_n      = cnt;
    gnt_n      = '0;
    done_n     = '0;
    op_valid_n = 1'b0;
    op_a_n     = op_a;
    op_b_n     = op_b;
    d_out_n    = d_out;
`ifndef MAC_SCHED_FIXED_PRIO_EN
    last_n     = last;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n     = ISSUE;
          win_n       = pick;
          op_a_n      = a_arr[pick];
          op_b_n      = b_arr[pick];
          gnt_n[pick] = 1'b1;
          op_valid_n  = 1'b1;
`ifndef MAC_SCHED_FIXED_PRIO_EN
          last_n      = pick;
`endif
        end
      end
      ISSUE: begin
        cnt_n   = 4'(LAT - 1);
        state_n = WAIT;
      end
      WAIT: begin
        // Counter runs LAT-1..0, so WAIT spans exactly LAT cycles.
        if (cnt == 4'd0) begin
          state_n     = RESP;
          d_out_n     = res_d;
          done_n[win] = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      win      <= '0;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      d_out    <= '0;
`ifndef MAC_SCHED_FIXED_PRIO_EN
      last     <= IW'(N_REQ - 1);
`endif
    end else begin
      state    <= state_n;
      win      <= win_n;
      cnt      <= cnt_n;
      gnt      <= gnt_n;
      done     <= done_n;
      op_valid <= op_valid_n;
      op_a     <= op_a_n;
      op_b     <= op_b_n;
      d_out    <= d_out_n;
`ifndef MAC_SCHED_FIXED_PRIO_EN
      last     <= last_n;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mac_scheduler.sv
// tb/tb_mac_scheduler.sv - scoreboard bench for mac_scheduler with a cycle-level reference model
module tb_mac_scheduler;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   op_a, op_b, res_d, d_out;
  logic           op_valid, busy;

  mac_scheduler #(.N_REQ(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_d(res_d), .done(done), .d_out(d_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: sum of the held operands.
  assign res_d = op_a + op_b;

  typedef struct { int cyc; logic [N-1:0] oh; logic [W-1:0] a; logic [W-1:0] b; } gexp_t;
  typedef struct { int cyc; logic [N-1:0] oh; logic [W-1:0] r; } dexp_t;

  gexp_t        gq[$];
  dexp_t        dq[$];
  logic [N-1:0] glog[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           next_ok = 0;
  int           m_last = N - 1;
  int           pend_edge = -1;
  logic [W-1:0] pend_res = '0;
  logic [W-1:0] exp_dout = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one operation occupies LAT+3 edges from its sampling edge.
  always @(posedge clk) begin : model
    int e, w;
    logic [W-1:0] ra, rb;
    logic [N-1:0] oh;
    e = cyc;
    cyc = cyc + 1;
    if (rst) begin
      gq.delete();
      dq.delete();
      next_ok   = e + 1;
      m_last    = N - 1;
      exp_dout  = '0;
      pend_edge = -1;
    end else begin
      if (e == pend_edge) exp_dout = pend_res;
      if (e >= next_ok && req != '0) begin
        w = -1;
`ifdef MAC_SCHED_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--)
          if (((req >> i) & 1) != 0) w = i;
`else
        for (int k = 1; k <= N; k++)
          if (w < 0 && ((req >> ((m_last + k) % N)) & 1) != 0) w = (m_last + k) % N;
        m_last = w;
`endif
        ra = W'(a_in >> (w * W));
        rb = W'(b_in >> (w * W));
        oh = N'(1) << w;
        pend_res  = W'((int'(ra) + int'(rb)) % (1 << W));
        pend_edge = e + LAT + 1;
        next_ok   = e + LAT + 3;
        gq.push_back('{cyc: e + 1, oh: oh, a: ra, b: rb});
        dq.push_back('{cyc: e + LAT + 2, oh: oh, r: pend_res});
      end
    end
  end

  always @(negedge clk) begin : monitor
    gexp_t ge;
    dexp_t de;
    chk("busy", 32'(busy), 32'(cyc < next_ok));
    chk("d_out", 32'(d_out), 32'(exp_dout));
    chk("op_valid", 32'(op_valid), 32'(gnt != '0));
    if (gnt != '0) begin
      glog.push_back(gnt);
      if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
      else begin
        ge = gq.pop_front();
        chk("gnt_cycle", cyc, ge.cyc);
        chk("gnt", 32'(gnt), 32'(ge.oh));
        chk("op_a", 32'(op_a), 32'(ge.a));
        chk("op_b", 32'(op_b), 32'(ge.b));
      end
    end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
      chk("gnt_missing", 32'(gnt), 32'(gq[0].oh));
      void'(gq.pop_front());
    end
    if (done != '0) begin
      if (dq.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        de = dq.pop_front();
        chk("done_cycle", cyc, de.cyc);
        chk("done", 32'(done), 32'(de.oh));
        chk("done_dout", 32'(d_out), 32'(de.r));
      end
    end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
      chk("done_missing", 32'(done), 32'(dq[0].oh));
      void'(dq.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done(input string nm, input logic [N-1:0] oh, input logic [W-1:0] r);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done != '0) got = 1;
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_done"}, 32'(done), 32'(oh));
      chk({nm, "_dout"}, 32'(d_out), 32'(r));
    end
  endtask

  task automatic single(input string nm, input int idx, input int a, input int b, input int r);
    wait_idle();
    @(posedge clk);
    #2;
    req  = N'(1) << idx;
    a_in = (N*W)'(a) << (idx * W);
    b_in = (N*W)'(b) << (idx * W);
    tick(1);
    req = '0;
    wait_done(nm, N'(1) << idx, W'(r));
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
`ifdef MAC_SCHED_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    rst = 1'b1;
    req = '1;
    tick(2);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op", 32'({op_valid, op_a, op_b}), 32'd0);
    chk("rst_dout_busy", 32'({d_out, busy}), 32'd0);

    // Held all-ones request: grant order and spacing.
    @(posedge clk);
    #2;
    rst  = 1'b0;
    a_in = N*W'($urandom);
    b_in = N*W'($urandom);
    tick(33);
    req = '0;
    wait_idle();
    chk("rr_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(rr_exp[i]));

    single("single", 2, 3, 5, 8);
    single("wrap", 0, 9, 9, 2);

    // Drop: req[1] cleared mid-WAIT still completes; req[3] seen only in WAIT is ignored.
    wait_idle();
    @(posedge clk);
    #2;
    req  = 4'b0010;
    a_in = (N*W)'(4) << (1 * W);
    b_in = (N*W)'(4) << (1 * W);
    tick(2);
    req = 4'b1000;
    tick(1);
    req = '0;
    wait_done("drop", 4'b0010, 4'd8);

    // Abort in WAIT: no done, d_out cleared, next request served.
    wait_idle();
    @(posedge clk);
    #2;
    req  = 4'b0001;
    a_in = 16'h0007;
    b_in = 16'h0006;
    tick(1);
    req = '0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dout", 32'(d_out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    single("after_abort", 2, 3, 5, 8);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      req  = N'($urandom & $urandom);
      a_in = N*W'($urandom);
      b_in = N*W'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst = 1'b0;
    req = '0;
    tick(LAT + 8);
    @(negedge clk);
    chk("gq_drained", gq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
